// File: rtl/btn_pkg.sv
// btn_pkg -- shared definitions for the multi-channel button debouncer.
//   RAW_IDLE_PULLUP / RAW_IDLE_PULLDOWN : raw pin level of a released button
//   hold_phase_e                        : long-press / auto-repeat phase
//   cnt_width()   : bits needed to hold counts 0..max_count
//   hold_width()  : hold counter width for the long-press timer
//   raw_idle()    : released raw level for a given ACTIVE_LOW setting
package btn_pkg;

  localparam logic RAW_IDLE_PULLUP   = 1'b1;
  localparam logic RAW_IDLE_PULLDOWN = 1'b0;

  typedef enum logic [1:0] {
    HOLD_LONG,
    HOLD_REPEAT,
    HOLD_DONE
  } hold_phase_e;

  function automatic int unsigned cnt_width(input longint unsigned max_count);
    return $clog2(max_count + 64'd1);
  endfunction

  function automatic int unsigned hold_width(input int unsigned long_c,
                                             input int unsigned rep_c);
    return cnt_width((long_c > rep_c) ? long_c : rep_c);
  endfunction

  function automatic logic raw_idle(input int unsigned active_low);
    return (active_low != 0) ? RAW_IDLE_PULLUP : RAW_IDLE_PULLDOWN;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch -- one debounced button channel.
//   clk, rst_n     : clock, asynchronous active-low reset
//   raw            : raw asynchronous button pin
//   level          : debounced state, 1 = pressed
//   press_pulse    : one-cycle strobe when a press is accepted
//   release_pulse  : one-cycle strobe when a release is accepted
//   long_pulse     : one-cycle strobe on long press / auto-repeat
// Long-press timing is built only when BTN_DEBOUNCE_LONG_PRESS_EN is defined;
// otherwise long_pulse is tied low.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 300000,
  parameter int unsigned ACTIVE_LOW    = 1,
  parameter int unsigned LONG_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned   DW       = cnt_width(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);
  localparam logic          RAW_IDLE = raw_idle(ACTIVE_LOW);

  // Parameter sanity: both thresholds must be at least one cycle.
  if (DEB_CYCLES == 0 || LONG_CYCLES == 0 ||
      hold_width(LONG_CYCLES, REPEAT_CYCLES) > 32) begin : g_bad_cfg
    $error("btn_debounce_ch: DEB_CYCLES and LONG_CYCLES must be >= 1");
  end

  logic          sync1, sync2;
  logic          pressed;
  logic          level_nx, press_nx, release_nx;
  logic [DW-1:0] deb_cnt, deb_cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RAW_IDLE;
      sync2 <= RAW_IDLE;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // XOR with the idle level maps either polarity onto 1 = pressed.
  assign pressed = sync2 ^ RAW_IDLE;

  always_comb begin
    deb_cnt_nx = '0;
    level_nx   = level;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    if (pressed != level) begin
      if (deb_cnt == DEB_LAST) begin
        level_nx   = pressed;
        press_nx   = pressed;
        release_nx = ~pressed;
      end else begin
        deb_cnt_nx = deb_cnt + DEB_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level         <= 1'b0;
      deb_cnt       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      level         <= level_nx;
      deb_cnt       <= deb_cnt_nx;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
    end
  end

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned   HW        = hold_width(LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  hold_phase_e   phase, phase_nx;
  logic [HW-1:0] hold_cnt, hold_cnt_nx;
  logic          long_nx;

  // The counter restarts after every strobe, so the first interval uses
  // LONG_CYCLES and later ones REPEAT_CYCLES; HOLD_DONE parks the timer
  // when repeat is disabled.
  always_comb begin
    phase_nx    = phase;
    hold_cnt_nx = hold_cnt;
    long_nx     = 1'b0;
    if (!level) begin
      phase_nx    = HOLD_LONG;
      hold_cnt_nx = '0;
    end else begin
      case (phase)
        HOLD_LONG: begin
          if (hold_cnt == LONG_LAST) begin
            long_nx     = 1'b1;
            hold_cnt_nx = '0;
            phase_nx    = (REPEAT_CYCLES == 0) ? HOLD_DONE : HOLD_REPEAT;
          end else begin
            hold_cnt_nx = hold_cnt + HOLD_ONE;
          end
        end
        HOLD_REPEAT: begin
          if (hold_cnt == REP_LAST) begin
            long_nx     = 1'b1;
            hold_cnt_nx = '0;
          end else begin
            hold_cnt_nx = hold_cnt + HOLD_ONE;
          end
        end
        default: begin
          hold_cnt_nx = hold_cnt;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= HOLD_LONG;
      hold_cnt   <= '0;
      long_pulse <= 1'b0;
    end else begin
      phase      <= phase_nx;
      hold_cnt   <= hold_cnt_nx;
      long_pulse <= long_nx;
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi -- N_CH independent debounced buttons.
//   clk, rst_n     : clock, asynchronous active-low reset
//   btn_in         : raw asynchronous button pins [N_CH]
//   btn_level      : debounced state per channel, 1 = pressed
//   press_pulse    : one-cycle strobe per accepted press
//   release_pulse  : one-cycle strobe per accepted release
//   long_pulse     : one-cycle strobe per long press / auto-repeat
// Define BTN_DEBOUNCE_LONG_PRESS_EN to build the long-press timers; without
// it long_pulse stays 0 and the port list is unchanged.
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int unsigned N_CH          = 5,
  parameter int unsigned DEB_CYCLES    = 300000,
  parameter int unsigned ACTIVE_LOW    = 1,
  parameter int unsigned LONG_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse
);

  if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
    $error("btn_debounce_multi: N_CH must be in 1..32");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .DEB_CYCLES   (DEB_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .raw          (btn_in[i]),
      .level        (btn_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i])
    );
  end

endmodule

// File: doc/btn_debounce_multi.md
BTN_DEBOUNCE_MULTI -- requirements
Module: btn_debounce_multi

Interface
REQ-001 SHALL have parameter N_CH, default 5: number of independent button channels (1..32).
REQ-002 SHALL have parameter DEB_CYCLES, default 300000: consecutive stable cycles required to accept a level change (>=1).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 means raw input low = pressed (pull-up); 0 means raw high = pressed.
REQ-004 SHALL have parameter LONG_CYCLES, default 25000000: held cycles before the first long_pulse (>=1).
REQ-005 SHALL have parameter REPEAT_CYCLES, default 5000000: held cycles between repeat long_pulses; 0 disables repeat.
REQ-006 SHALL have port clk, input, 1: rising-edge clock.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port btn_in, input, N_CH: raw asynchronous button pins.
REQ-009 SHALL have port btn_level, output, N_CH: debounced state, 1 = pressed, regardless of polarity.
REQ-010 SHALL have port press_pulse, output, N_CH: one-cycle strobe on an accepted press.
REQ-011 SHALL have port release_pulse, output, N_CH: one-cycle strobe on an accepted release.
REQ-012 SHALL have port long_pulse, output, N_CH: one-cycle strobe on long-press and auto-repeat.

Function
REQ-013 SHALL synchronise each btn_in bit through two flops, then normalise polarity so 1 = pressed.
REQ-014 SHALL keep a per-channel debounce counter sized $clog2(DEB_CYCLES+1) bits.
- Counter clears on any cycle where the synced state equals btn_level.
- Counter increments on each cycle of mismatch.
REQ-015 SHALL update btn_level and clear the counter on the cycle the counter reaches DEB_CYCLES-1 while still mismatched, i.e. after exactly DEB_CYCLES mismatched cycles.
REQ-016 SHALL reject a glitch shorter than DEB_CYCLES cycles: the counter restarts from 0 and btn_level is unchanged.
REQ-017 SHALL give a latency from a btn_in edge to a btn_level change of exactly 2 + DEB_CYCLES clk cycles for a clean edge.
REQ-018 SHALL register press_pulse/release_pulse so each is high for exactly one cycle, the same cycle btn_level first shows the new value.
REQ-019 SHALL run channels fully independently; simultaneous events on several channels each produce their own pulses in the same cycle.
REQ-020 SHALL never assert press_pulse and release_pulse on the same channel in the same cycle.

Reset
REQ-021 SHALL, while rst_n=0, drive the sync flops to the inactive raw level (ACTIVE_LOW ? 1 : 0).
REQ-022 SHALL, while rst_n=0, drive btn_level=0, all pulses=0, and all counters=0.
REQ-023 SHALL NOT emit a press_pulse at reset release if a button is already held; the press is accepted only after the normal DEB_CYCLES debounce, then pulses once.
REQ-024 SHALL abort any in-progress debounce or hold count on reset mid-operation with no pulse.

Configuration
REQ-025 SHALL, when macro BTN_DEBOUNCE_LONG_PRESS_EN is defined, implement a per-channel hold counter of $clog2(max(LONG_CYCLES,REPEAT_CYCLES)+1) bits.
- Counts while btn_level=1; clears when btn_level=0.
- long_pulse fires when held count reaches LONG_CYCLES, then every REPEAT_CYCLES thereafter if REPEAT_CYCLES>0.
- Release before LONG_CYCLES yields no long_pulse.
REQ-026 SHALL, when BTN_DEBOUNCE_LONG_PRESS_EN is undefined, omit the hold logic and tie long_pulse to 0 while keeping the port list unchanged.

Structure
REQ-027 SHALL place the polarity constants and the shared counter-width helper function in package btn_pkg.
REQ-028 SHALL implement one channel in sub-module btn_debounce_ch, instantiated N_CH times via generate.

Verification (N_CH=3, DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=1)
REQ-029 SHALL check: ch0 driven low and held -> btn_level[0] rises 6 cycles after the edge, with press_pulse[0] high for exactly that one cycle.
REQ-030 SHALL check: ch1 low pulse of 3 cycles -> btn_level[1] stays 0 and no pulses occur.
REQ-031 SHALL check: ch0 held for 40 cycles after acceptance (macro on) -> long_pulse[0] at held cycles 20, 28 and 36; macro off -> long_pulse stays 0.
REQ-032 SHALL check: ch0 and ch2 released in the same cycle -> release_pulse = 3'b101 in one cycle, 6 cycles later.
REQ-033 SHALL check: button held low through reset release -> no pulse during reset, press_pulse 6 cycles after rst_n rises.
REQ-034 SHALL check: rst_n asserted mid-count (counter=2) -> all outputs 0 immediately, and no pulse after release while the input is inactive.
